uart_sdram_seq: RTL and testbench
=================================

Name: uart_sdram_seq

Overview:
- Frame sequencer between uart_rx/uart_tx and the sdram_top FIFO ports; replaces the fixed-count glue logic in the UART-SDRAM top level.
- Packs received bytes into SDRAM words and closes a frame on a full burst or an idle timeout.
- After a settle delay it requests readback and drains the read FIFO to uart_tx, pacing bytes with tx_busy.
- Each frame gets its own SDRAM region; the base address advances per frame and wraps.

Parameters:
- PACK_BYTES, 2, bytes per 16-bit SDRAM word; legal values 1 or 2.
- BURST_MAX, 10, maximum words per frame; range 1..2^LEN_W-1.
- IDLE_MAX, 20000, clk cycles with no rx_flag that close a non-empty frame.
- WAIT_MAX, 750, clk cycles from the last FIFO write to rd_valid assertion.
- ADDR_W, 24, SDRAM address width.
- LEN_W, 10, burst-length and FIFO-count width.
- REGION_MAX, 16, number of frame regions before the base address wraps to 0.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rstn  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from uart_rx.
- rx_flag  in  1  one-cycle strobe; rx_data valid.
- wr_fifo_wr_req  out  1  write strobe to the SDRAM write FIFO.
- wr_fifo_wr_data  out  16  packed word.
- sdram_wr_b_addr  out  ADDR_W  write base address of the current frame.
- sdram_rd_b_addr  out  ADDR_W  read base address; equals the write base address of the frame.
- burst_len  out  LEN_W  words in the current frame.
- rd_valid  out  1  readback enable to sdram_top.
- rd_fifo_num  in  LEN_W  read FIFO fill level.
- rd_fifo_rd_req  out  1  read FIFO pop; data is valid the following cycle.
- rd_fifo_rd_data  in  16  read FIFO data.
- tx_busy  in  1  uart_tx busy.
- tx_flag  out  1  one-cycle send strobe.
- tx_data  out  8  byte to transmit.
- rx_drop  out  1  sticky flag: a byte arrived outside FILL; cleared only by reset.

Behaviour:
- Async reset clears every output, register and counter to 0; the FSM enters FILL.
- States: FILL, SETTLE, READ, DRAIN_POP, DRAIN_TX, NEXT.
- FILL, byte accept:
  - Each rx_flag stores one byte. With PACK_BYTES=2, the first byte goes to [7:0] and the second to [15:8].
  - On word completion, wr_fifo_wr_req pulses for 1 cycle in the cycle after the final rx_flag; word_cnt increments.
  - byte_cnt counts accepted bytes.
- FILL, idle timer:
  - The timer resets on every rx_flag and runs only while byte_cnt>0.
- FILL, frame close:
  - Close when word_cnt==BURST_MAX, or when the idle timer reaches IDLE_MAX with byte_cnt>0.
  - If a word is partially filled at timeout, flush it with the upper byte 0 (one extra write pulse).
  - burst_len latches the final word count.
  - An empty frame never closes.
- SETTLE: count WAIT_MAX cycles after the last write pulse, then go to READ.
- READ:
  - rd_valid=1 from READ entry.
  - rd_valid drops to 0 in the cycle after rd_fifo_num>=burst_len, then go to DRAIN_POP.
- DRAIN_POP: 1-cycle rd_fifo_rd_req; capture rd_fifo_rd_data on the next cycle.
- DRAIN_TX:
  - For each valid byte of the word, low byte first: wait for tx_busy==0, pulse tx_flag with tx_data, then wait 2 guard cycles before sampling tx_busy again.
  - On the last word, send only the remaining bytes (byte_cnt mod PACK_BYTES, where 0 means a full word), so the padded byte is never transmitted.
  - When the word is done, return to DRAIN_POP until burst_len words have been popped, then go to NEXT.
- NEXT (1 cycle):
  - base += BURST_MAX; at region REGION_MAX-1 it wraps to 0.
  - Clear the counters and return to FILL.
- rx_flag in any state except FILL: byte dropped, rx_drop set.
- rx_flag in the same cycle as an idle timeout: the byte is accepted and the timeout is cancelled.
- Counter widths:
  - byte_cnt is LEN_W+1 bits.
  - The idle and settle counters are sized by $clog2 of their maximum.
  - The address arithmetic is ADDR_W wide and never overflows, given BURST_MAX*REGION_MAX < 2^ADDR_W (elaboration-time check).
- Reset mid-frame: all state is discarded with no flush; the SDRAM FIFOs are reset by the top level through the same rstn.

Decomposition:
- Package uart_sdram_pkg holds:
  - the state encoding enum;
  - the constant BYTE_W=8;
  - the function clog2_min1.
- One sub-module, byte_packer: PACK_BYTES-to-word assembly, flush-on-timeout and the write strobe; the FSM lives in the top.

Test Plan:
- Full burst: PACK_BYTES=2, BURST_MAX=4, send 8 bytes 0x01..0x08 → 4 writes 0x0201,0x0403,0x0605,0x0807, burst_len=4, rd_valid after 750 cycles, tx emits 01..08 in order.
- Partial frame: send 3 bytes A1,B2,C3, then idle for IDLE_MAX cycles → writes 0xB2A1 and 0x00C3, burst_len=2, tx emits exactly 3 bytes A1,B2,C3.
- Region wrap: REGION_MAX=2, run 3 frames → wr_b_addr sequence 0, BURST_MAX, 0; rd_b_addr matches the write base address of each frame.
- Backpressure: hold tx_busy=1 for 5000 cycles during DRAIN_TX → no tx_flag while busy; no byte lost or duplicated; rd_fifo_rd_req count equals burst_len.
- Drop and race: rx_flag during SETTLE → rx_drop=1 and no extra write; rx_flag on the exact timeout cycle → byte accepted and the frame stays open.
- Reset mid-DRAIN: deassert rstn asynchronously → all outputs 0 immediately; after release the FSM is in FILL with base address 0.

Source files
------------

// File: rtl/uart_sdram_seq_pkg.sv
// Shared types and helpers for the UART <-> SDRAM frame sequencer.
package uart_sdram_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        FILL      = 3'd0,
        SETTLE    = 3'd1,
        READ      = 3'd2,
        DRAIN_POP = 3'd3,
        DRAIN_TX  = 3'd4,
        NEXT      = 3'd5
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/uart_sdram_seq_if.sv
// Bundle of the uart_rx/uart_tx and sdram_top FIFO signals seen by the sequencer.
interface uart_sdram_seq_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10
);
    import uart_sdram_pkg::*;

    // All *_flag and *_req signals are single-cycle strobes with no ready
    // return; rd_fifo_rd_data is valid the cycle after rd_fifo_rd_req.
    logic [BYTE_W-1:0]   rx_data;
    logic                rx_flag;
    logic                wr_fifo_wr_req;
    logic [2*BYTE_W-1:0] wr_fifo_wr_data;
    logic [ADDR_W-1:0]   sdram_wr_b_addr;
    logic [ADDR_W-1:0]   sdram_rd_b_addr;
    logic [LEN_W-1:0]    burst_len;
    logic                rd_valid;
    logic [LEN_W-1:0]    rd_fifo_num;
    logic                rd_fifo_rd_req;
    logic [2*BYTE_W-1:0] rd_fifo_rd_data;
    logic                tx_busy;
    logic                tx_flag;
    logic [BYTE_W-1:0]   tx_data;
    logic                rx_drop;
    state_t              fsm_state;

    modport master (
        input  rx_data, rx_flag, rd_fifo_num, rd_fifo_rd_data, tx_busy,
        output wr_fifo_wr_req, wr_fifo_wr_data, sdram_wr_b_addr, sdram_rd_b_addr,
               burst_len, rd_valid, rd_fifo_rd_req, tx_flag, tx_data, rx_drop, fsm_state
    );

    modport slave (
        output rx_data, rx_flag, rd_fifo_num, rd_fifo_rd_data, tx_busy,
        input  wr_fifo_wr_req, wr_fifo_wr_data, sdram_wr_b_addr, sdram_rd_b_addr,
               burst_len, rd_valid, rd_fifo_rd_req, tx_flag, tx_data, rx_drop, fsm_state
    );
endinterface

// File: rtl/uart_sdram_seq_byte_packer.sv
// Assembles received bytes into 16-bit SDRAM words, low byte first.
module byte_packer
    import uart_sdram_pkg::*;
#(
    parameter int PACK_BYTES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                accept,
    input  logic [BYTE_W-1:0]   data,
    input  logic                flush,
    input  logic                clear,
    output logic                wr_req,
    output logic [2*BYTE_W-1:0] wr_data,
    output logic                word_done,
    output logic                partial
);
    logic              lane;
    logic [BYTE_W-1:0] lo;

    assign partial   = (PACK_BYTES == 2) && lane;
    assign word_done = accept && ((PACK_BYTES == 1) || lane);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane    <= 1'b0;
            lo      <= '0;
            wr_req  <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_req <= 1'b0;
            if (clear) begin
                lane <= 1'b0;
            end else if (accept) begin
                if (word_done) begin
                    wr_req  <= 1'b1;
                    lane    <= 1'b0;
                    wr_data <= (PACK_BYTES == 1) ? {{BYTE_W{1'b0}}, data} : {data, lo};
                end else begin
                    lo   <= data;
                    lane <= 1'b1;
                end
            end else if (flush && partial) begin
                // Half-filled word at timeout goes out with a zero upper byte.
                wr_req  <= 1'b1;
                lane    <= 1'b0;
                wr_data <= {{BYTE_W{1'b0}}, lo};
            end
        end
    end
endmodule

// File: rtl/uart_sdram_seq.sv
// Frame sequencer: packs UART bytes into SDRAM bursts, then reads them back to uart_tx.
module uart_sdram_seq
    import uart_sdram_pkg::*;
#(
    parameter int PACK_BYTES = 2,
    parameter int BURST_MAX  = 10,
    parameter int IDLE_MAX   = 20000,
    parameter int WAIT_MAX   = 750,
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 10,
    parameter int REGION_MAX = 16
) (
    input  logic             clk,
    input  logic             rstn,
    uart_sdram_seq_if.master bus
);
    localparam int IDLE_W = clog2_min1(IDLE_MAX);
    localparam int SET_W  = clog2_min1(WAIT_MAX);
    localparam int REG_W  = clog2_min1(REGION_MAX);

    if (PACK_BYTES != 1 && PACK_BYTES != 2) begin : g_pack_chk
        $error("PACK_BYTES must be 1 or 2");
    end
    if (BURST_MAX < 1 || BURST_MAX >= (1 << LEN_W)) begin : g_burst_chk
        $error("BURST_MAX out of range for LEN_W");
    end
    if (longint'(BURST_MAX) * longint'(REGION_MAX) >= (longint'(1) << ADDR_W)) begin : g_addr_chk
        $error("BURST_MAX*REGION_MAX does not fit in ADDR_W");
    end

    state_t              state, next_state;
    logic [LEN_W:0]      byte_cnt;
    logic [LEN_W-1:0]    word_cnt, pop_cnt, burst_len_q;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic [REG_W-1:0]    region;
    logic [ADDR_W-1:0]   base;
    logic [2*BYTE_W-1:0] word_q;
    logic                cap_pend;
    logic [1:0]          byte_idx, nbytes, guard;
    logic                tx_flag_q, rx_drop_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                accept, timeout, close_full, word_done, partial;

    assign accept     = bus.rx_flag && (state == FILL);
    // An rx_flag on the timeout cycle wins: the byte is kept and the frame stays open.
    assign timeout    = (state == FILL) && !bus.rx_flag && (byte_cnt != '0) &&
                        (idle_cnt == IDLE_W'(IDLE_MAX - 1));
    assign close_full = word_done && (word_cnt == LEN_W'(BURST_MAX - 1));

    always_comb begin
        nbytes = 2'(PACK_BYTES);
        if (PACK_BYTES == 2 && pop_cnt == burst_len_q && byte_cnt[0])
            nbytes = 2'd1;
    end

    byte_packer #(.PACK_BYTES(PACK_BYTES)) u_packer (
        .clk       (clk),
        .rstn      (rstn),
        .accept    (accept),
        .data      (bus.rx_data),
        .flush     (timeout),
        .clear     (state == NEXT),
        .wr_req    (bus.wr_fifo_wr_req),
        .wr_data   (bus.wr_fifo_wr_data),
        .word_done (word_done),
        .partial   (partial)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= FILL;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:      if (close_full || timeout) next_state = SETTLE;
            SETTLE:    if (settle_cnt == SET_W'(WAIT_MAX - 1)) next_state = READ;
            READ:      if (bus.rd_fifo_num >= burst_len_q) next_state = DRAIN_POP;
            DRAIN_POP: next_state = DRAIN_TX;
            DRAIN_TX:  if (!cap_pend && byte_idx == nbytes)
                           next_state = (pop_cnt == burst_len_q) ? NEXT : DRAIN_POP;
            NEXT:      next_state = FILL;
            default:   next_state = FILL;
        endcase
    end

    always_comb begin
        bus.rd_valid       = (state == READ);
        bus.rd_fifo_rd_req = (state == DRAIN_POP);
        bus.fsm_state      = state;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt    <= '0;
            word_cnt    <= '0;
            pop_cnt     <= '0;
            burst_len_q <= '0;
            idle_cnt    <= '0;
            settle_cnt  <= '0;
            region      <= '0;
            base        <= '0;
            word_q      <= '0;
            cap_pend    <= 1'b0;
            byte_idx    <= '0;
            guard       <= '0;
            tx_flag_q   <= 1'b0;
            tx_data_q   <= '0;
            rx_drop_q   <= 1'b0;
        end else begin
            tx_flag_q <= 1'b0;
            if (guard != '0) guard <= guard - 2'd1;
            if (bus.rx_flag && state != FILL) rx_drop_q <= 1'b1;
            case (state)
                FILL: begin
                    settle_cnt <= '0;
                    if (accept) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        idle_cnt <= '0;
                        if (word_done)  word_cnt    <= word_cnt + 1'b1;
                        if (close_full) burst_len_q <= word_cnt + 1'b1;
                    end else if (timeout) begin
                        word_cnt    <= word_cnt + LEN_W'(partial);
                        burst_len_q <= word_cnt + LEN_W'(partial);
                        idle_cnt    <= '0;
                    end else if (byte_cnt != '0) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                DRAIN_POP: begin
                    pop_cnt  <= pop_cnt + 1'b1;
                    cap_pend <= 1'b1;
                end
                DRAIN_TX: begin
                    if (cap_pend) begin
                        word_q   <= bus.rd_fifo_rd_data;
                        cap_pend <= 1'b0;
                        byte_idx <= '0;
                    end else if (byte_idx != nbytes && guard == '0 && !bus.tx_busy) begin
                        tx_flag_q <= 1'b1;
                        tx_data_q <= (byte_idx == 2'd0) ? word_q[BYTE_W-1:0] : word_q[2*BYTE_W-1:BYTE_W];
                        byte_idx  <= byte_idx + 2'd1;
                        guard     <= 2'd2;
                    end
                end
                NEXT: begin
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    pop_cnt  <= '0;
                    idle_cnt <= '0;
                    if (region == REG_W'(REGION_MAX - 1)) begin
                        region <= '0;
                        base   <= '0;
                    end else begin
                        region <= region + 1'b1;
                        base   <= base + ADDR_W'(BURST_MAX);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sdram_wr_b_addr = base;
    assign bus.sdram_rd_b_addr = base;
    assign bus.burst_len       = burst_len_q;
    assign bus.tx_flag         = tx_flag_q;
    assign bus.tx_data         = tx_data_q;
    assign bus.rx_drop         = rx_drop_q;
endmodule

// File: tb/tb_uart_sdram_seq.sv
// Scoreboard bench for uart_sdram_seq with small SDRAM-FIFO and uart_tx models.
module tb_uart_sdram_seq;
    import uart_sdram_pkg::*;

    localparam int PACK_BYTES = 2;
    localparam int BURST_MAX  = 4;
    localparam int IDLE_MAX   = 40;
    localparam int WAIT_MAX   = 750;
    localparam int ADDR_W     = 24;
    localparam int LEN_W      = 10;
    localparam int REGION_MAX = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } frame_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    uart_sdram_seq_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    uart_sdram_seq #(
        .PACK_BYTES(PACK_BYTES), .BURST_MAX(BURST_MAX), .IDLE_MAX(IDLE_MAX),
        .WAIT_MAX(WAIT_MAX), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .REGION_MAX(REGION_MAX)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0]       exp_wr_q[$];
    logic [7:0]        exp_tx_q[$];
    frame_t            exp_frame_q[$];
    logic [15:0]       stored_q[$];
    logic [15:0]       rdq[$];
    logic [ADDR_W-1:0] exp_base = '0;
    int                last_wr_cyc = 0;
    int                rd_req_cnt = 0;
    int                busy_cnt = 0;
    logic              bp_hold = 1'b0;
    logic              prev_rdv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        @(posedge clk); #1;
        bus.rx_flag = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string name, input state_t target, input int budget);
        int n = 0;
        while (bus.fsm_state != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.fsm_state, target);
    endtask

    // Monitor plus environment models: SDRAM FIFOs and a uart_tx with a busy window.
    initial begin
        frame_t f;
        bus.rd_fifo_num     = '0;
        bus.rd_fifo_rd_data = '0;
        bus.tx_busy         = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stored_q.delete();
                rdq.delete();
                busy_cnt        = 0;
                prev_rdv        = 1'b0;
                bus.rd_fifo_num = '0;
                bus.tx_busy     = bp_hold;
            end else begin
                if (bus.wr_fifo_wr_req) begin
                    stored_q.push_back(bus.wr_fifo_wr_data);
                    last_wr_cyc = cyc;
                    check("wr_b_addr", bus.sdram_wr_b_addr, exp_base);
                    if (exp_wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wr_unexpected: got 0x%0h with no write expected", bus.wr_fifo_wr_data);
                    end else begin
                        check("wr_data", bus.wr_fifo_wr_data, exp_wr_q.pop_front());
                    end
                end
                if (bus.rd_fifo_rd_req) begin
                    rd_req_cnt++;
                    if (rdq.size() > 0) bus.rd_fifo_rd_data = rdq.pop_front();
                end else if (bus.rd_valid && stored_q.size() > 0 && (cyc % 4) == 0) begin
                    rdq.push_back(stored_q.pop_front());
                end
                bus.rd_fifo_num = LEN_W'(rdq.size());

                if (bus.rd_valid && !prev_rdv) begin
                    if (exp_frame_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rd_valid_unexpected: got rise at cycle %0d with no frame expected", cyc);
                    end else begin
                        f = exp_frame_q.pop_front();
                        check("rd_b_addr", bus.sdram_rd_b_addr, f.addr);
                        check("burst_len", bus.burst_len, f.len);
                        check("rd_valid_latency", cyc - last_wr_cyc, WAIT_MAX);
                    end
                end
                prev_rdv = bus.rd_valid;

                if (bus.tx_flag) begin
                    check("tx_while_busy", bus.tx_busy, 0);
                    if (exp_tx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got 0x%0h with no byte expected", bus.tx_data);
                    end else begin
                        check("tx_data", bus.tx_data, exp_tx_q.pop_front());
                    end
                    busy_cnt = 20;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                end
                bus.tx_busy = bp_hold || (busy_cnt != 0);
            end
        end
    end

    // Stimulus
    initial begin
        logic [7:0]  f1_bytes[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        logic [15:0] f1_words[4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
        logic [7:0]  f3_bytes[8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        logic [15:0] f3_words[4] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};

        bus.rx_data = '0;
        bus.rx_flag = 1'b0;
        #1 rstn = 1'b0;
        #2;
        check("rst_wr_req", bus.wr_fifo_wr_req, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_tx_flag", bus.tx_flag, 0);
        check("rst_burst_len", bus.burst_len, 0);
        check("rst_rx_drop", bus.rx_drop, 0);
        check("rst_state", bus.fsm_state, FILL);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // Frame 1: full burst, then a dropped byte during SETTLE
        exp_base = 24'd0;
        foreach (f1_words[i]) exp_wr_q.push_back(f1_words[i]);
        foreach (f1_bytes[i]) exp_tx_q.push_back(f1_bytes[i]);
        exp_frame_q.push_back('{addr: 24'd0, len: 10'd4});
        rd_req_cnt = 0;
        foreach (f1_bytes[i]) send_byte(f1_bytes[i], 5);
        repeat (20) @(posedge clk);
        #1;
        send_byte(8'hEE, 2);
        check("rx_drop_settle", bus.rx_drop, 1);
        wait_state("f1_next", NEXT, 20000);
        check("f1_rd_req_cnt", rd_req_cnt, 4);
        @(posedge clk); #1;

        // Frame 2: second byte lands on the exact timeout cycle, then a real timeout
        exp_base = 24'd4;
        exp_wr_q.push_back(16'hB2A1);
        exp_wr_q.push_back(16'h00C3);
        exp_tx_q.push_back(8'hA1);
        exp_tx_q.push_back(8'hB2);
        exp_tx_q.push_back(8'hC3);
        exp_frame_q.push_back('{addr: 24'd4, len: 10'd2});
        rd_req_cnt = 0;
        send_byte(8'hA1, IDLE_MAX - 1);
        send_byte(8'hB2, 3);
        check("race_frame_open", bus.fsm_state, FILL);
        send_byte(8'hC3, 0);
        wait_state("f2_next", NEXT, 20000);
        check("f2_rd_req_cnt", rd_req_cnt, 2);
        @(posedge clk); #1;

        // Frame 3: region wrap back to 0, long tx_busy hold during drain
        exp_base = 24'd0;
        foreach (f3_words[i]) exp_wr_q.push_back(f3_words[i]);
        foreach (f3_bytes[i]) exp_tx_q.push_back(f3_bytes[i]);
        exp_frame_q.push_back('{addr: 24'd0, len: 10'd4});
        rd_req_cnt = 0;
        foreach (f3_bytes[i]) send_byte(f3_bytes[i], 3);
        wait_state("f3_drain", DRAIN_TX, 20000);
        bp_hold = 1'b1;
        repeat (5000) @(posedge clk);
        #1;
        check("bp_still_draining", bus.fsm_state, DRAIN_TX);
        bp_hold = 1'b0;
        wait_state("f3_next", NEXT, 20000);
        check("f3_rd_req_cnt", rd_req_cnt, 4);
        @(posedge clk); #1;

        // Frame 4: asynchronous reset in the middle of the drain
        exp_base = 24'd4;
        exp_wr_q.push_back(16'h6655);
        exp_wr_q.push_back(16'h0077);
        exp_frame_q.push_back('{addr: 24'd4, len: 10'd2});
        bp_hold = 1'b1;
        send_byte(8'h55, 3);
        send_byte(8'h66, 3);
        send_byte(8'h77, 3);
        wait_state("f4_drain", DRAIN_TX, 20000);
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_burst_len", bus.burst_len, 0);
        check("mid_rst_wr_b_addr", bus.sdram_wr_b_addr, 0);
        check("mid_rst_rd_b_addr", bus.sdram_rd_b_addr, 0);
        check("mid_rst_rd_req", bus.rd_fifo_rd_req, 0);
        check("mid_rst_tx_flag", bus.tx_flag, 0);
        check("mid_rst_rx_drop", bus.rx_drop, 0);
        check("mid_rst_state", bus.fsm_state, FILL);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        bp_hold = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_state", bus.fsm_state, FILL);
        check("post_rst_base", bus.sdram_wr_b_addr, 0);

        check("exp_wr_left", exp_wr_q.size(), 0);
        check("exp_tx_left", exp_tx_q.size(), 0);
        check("exp_frame_left", exp_frame_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
